fft_mag_writer: RTL and testbench

// - Producer side of the FFT magnitude BRAM consumed by FFT_energy (reader: bram_addr/data, ready/done).
// - Takes the streaming FFT output, computes a 16-bit magnitude per bin and writes one frame into BRAM.
// - Then raises ready and holds off further writes until the reader reports done.
// - Frames arriving while the reader owns the BRAM are dropped and counted.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/mag_approx.sv | 55 +++++
 rtl/fft_mag_writer.sv | 124 ++++++++++++
 tb/tb_fft_mag_writer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared frame constants, writer states and magnitude helper
package fft_pkg;

  localparam int FRAME_LEN = 1024;
  localparam int AW        = 10;
  localparam int DW        = 16;

  typedef enum logic [2:0] {
    SYNC,
    CAPTURE,
    FLUSH,
    READY,
    WAIT_DONE,
    ARM
  } state_t;

  // Unsigned absolute value; the most negative input maps to 2^(DW-1) without wrapping
  function automatic logic [DW-1:0] abs_u(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + {{(DW-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/mag_approx.sv
// rtl/mag_approx.sv - two-stage alpha-max-beta-min magnitude, max + min/4
module mag_approx
  import fft_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  output logic [DW-1:0] out_mag
);

  logic [DW-1:0] re_abs;
  logic [DW-1:0] im_abs;
  logic          v1;
  logic [DW-1:0] max_q;
  logic [DW-1:0] min_q;

  // Component magnitudes feeding the compare stage
  always_comb begin
    re_abs = abs_u(in_re);
    im_abs = abs_u(in_im);
  end

  // Stage 1: order the two magnitudes into max/min
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1    <= 1'b0;
      max_q <= '0;
      min_q <= '0;
    end else begin
      v1 <= in_valid;
      if (re_abs >= im_abs) begin
        max_q <= re_abs;
        min_q <= im_abs;
      end else begin
        max_q <= im_abs;
        min_q <= re_abs;
      end
    end
  end

  // Stage 2: max + min/4 tops out at 40960, so it always fits DW bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
    end else begin
      out_valid <= v1;
      out_mag   <= max_q + (min_q >> 2);
    end
  end

endmodule

// File: rtl/fft_mag_writer.sv
// rtl/fft_mag_writer.sv - writes one FFT magnitude frame into BRAM and hands it to the reader
module fft_mag_writer
  import fft_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic [2*DW-1:0] fft_tdata,
  input  logic            fft_tvalid,
  input  logic            fft_tlast,
  output logic            fft_tready,
  output logic            bram_we,
  output logic [AW-1:0]   bram_waddr,
  output logic [DW-1:0]   bram_wdata,
  output logic            ready,
  input  logic            done,
  output logic [7:0]      drop_count,
  output logic            sync_err
);

  localparam logic [AW-1:0] LAST_BIN = AW'(FRAME_LEN - 1);

  state_t        state;
  logic [AW-1:0] bin_cnt;
  logic [AW-1:0] addr_q;
  logic          flush_cnt;
  logic          cap_valid;

  // The block never back-pressures; it only deasserts tready while held in reset
  assign fft_tready = reset_n;
  assign cap_valid  = fft_tvalid && (state == CAPTURE);

  mag_approx u_mag (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (cap_valid),
    .in_re    (fft_tdata[DW-1:0]),
    .in_im    (fft_tdata[2*DW-1:DW]),
    .out_valid(bram_we),
    .out_mag  (bram_wdata)
  );

  // Bin index travels alongside the magnitude pipeline so address and data line up
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      bram_waddr <= '0;
    end else begin
      if (cap_valid) addr_q <= bin_cnt;
      bram_waddr <= addr_q;
    end
  end

  // Frame alignment, capture, reader handshake and dropped-frame accounting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC;
      bin_cnt    <= '0;
      flush_cnt  <= 1'b0;
      ready      <= 1'b0;
      sync_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      sync_err <= 1'b0;
      // A whole frame ending while the reader owns the BRAM is lost
      if (fft_tvalid && fft_tlast && (state inside {FLUSH, READY, WAIT_DONE})
          && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      case (state)
        SYNC: begin
          if (fft_tvalid && fft_tlast) begin
            state   <= CAPTURE;
            bin_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (fft_tvalid) begin
            if (fft_tlast) begin
              bin_cnt <= '0;
              if (bin_cnt == LAST_BIN) begin
                state     <= FLUSH;
                flush_cnt <= 1'b0;
              end else begin
                // Short frame: restart the bin count but never flag it ready
                sync_err <= 1'b1;
              end
            end else if (bin_cnt == LAST_BIN) begin
              // Frame overran without tlast: alignment is lost
              sync_err <= 1'b1;
              bin_cnt  <= '0;
              state    <= SYNC;
            end else begin
              bin_cnt <= bin_cnt + AW'(1);
            end
          end
        end
        FLUSH: begin
          // Two cycles let the last magnitude reach the BRAM before ready rises
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (!done) begin
            ready <= 1'b0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done) state <= ARM;
        end
        ARM: begin
          if (fft_tvalid && fft_tlast) begin
            state   <= CAPTURE;
            bin_cnt <= '0;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_mag_writer.sv
// tb/tb_fft_mag_writer.sv - randomized self-checking bench for fft_mag_writer
module tb_fft_mag_writer;

  localparam int N = 1024;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fft_tdata = '0;
  logic        fft_tvalid = 1'b0;
  logic        fft_tlast = 1'b0;
  logic        fft_tready;
  logic        bram_we;
  logic [9:0]  bram_waddr;
  logic [15:0] bram_wdata;
  logic        ready;
  logic        done = 1'b1;
  logic [7:0]  drop_count;
  logic        sync_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_mem [N];
  int obs_mem [N];
  int wr_cyc [N];
  int beat_cyc [N];
  int wr_cnt = 0;
  int se_cnt = 0;
  int se_wide = 0;
  int we_in_ready = 0;
  int ready_rises = 0;
  int ready_rise_cyc = -1;
  int last_cyc = 0;
  int exp_drop = 0;
  logic ready_q = 1'b0;
  logic se_q = 1'b0;

  fft_mag_writer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fft_tdata (fft_tdata),
    .fft_tvalid(fft_tvalid),
    .fft_tlast (fft_tlast),
    .fft_tready(fft_tready),
    .bram_we   (bram_we),
    .bram_waddr(bram_waddr),
    .bram_wdata(bram_wdata),
    .ready     (ready),
    .done      (done),
    .drop_count(drop_count),
    .sync_err  (sync_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bram_we === 1'b1) begin
      obs_mem[bram_waddr] = int'(bram_wdata);
      wr_cyc[bram_waddr]  = cyc;
      wr_cnt++;
      if (ready === 1'b1) we_in_ready++;
    end
    if (sync_err === 1'b1 && !se_q) se_cnt++;
    if (sync_err === 1'b1 && se_q) se_wide++;
    if (ready === 1'b1 && !ready_q) begin
      ready_rises++;
      ready_rise_cyc = cyc;
    end
    ready_q = (ready === 1'b1);
    se_q    = (sync_err === 1'b1);
  end

  function automatic int mag_ref(input logic [15:0] re, input logic [15:0] im);
    int a, b, hi, lo;
    a = int'($signed(re));
    b = int'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    return hi + lo / 4;
  endfunction

  function automatic int mem_errs();
    int e = 0;
    for (int i = 0; i < N; i++) if (obs_mem[i] != exp_mem[i]) e++;
    return e;
  endfunction

  function automatic int timing_errs();
    int e = 0;
    for (int i = 0; i < N; i++) if (wr_cyc[i] != beat_cyc[i] + 2) e++;
    return e;
  endfunction

  task automatic drive(input logic [15:0] re, input logic [15:0] im, input logic last,
                       input logic valid);
    @(negedge clock);
    fft_tdata  = {im, re};
    fft_tlast  = last;
    fft_tvalid = valid;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  // kind 0: re=i, im=0; kind 1: random; kind 2: spec corner values in bins 0..2, random after
  task automatic send_frame(input int n, input int last_idx, input int kind, input int gap_pct,
                            input bit cap);
    logic [15:0] re, im;
    if (cap) begin
      for (int i = 0; i < N; i++) begin
        obs_mem[i] = -1;
        wr_cyc[i]  = -1;
      end
    end
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) drive(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      re = 16'($urandom);
      im = 16'($urandom);
      if (kind == 0) begin
        re = 16'(i);
        im = 16'h0;
      end else if (kind == 2 && i == 0) begin
        re = 16'h8000;
        im = 16'h8000;
      end else if (kind == 2 && i == 1) begin
        re = 16'(3000);
        im = 16'(-4000);
      end else if (kind == 2 && i == 2) begin
        re = 16'h0;
        im = 16'h0;
      end
      drive(re, im, (i == last_idx), 1'b1);
      if (cap && i < N) begin
        beat_cyc[i] = cyc;
        exp_mem[i]  = mag_ref(re, im);
      end
      last_cyc = cyc;
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    for (int k = 0; k < limit && ready !== 1'b1; k++) @(negedge clock);
    ok = (ready === 1'b1);
    @(negedge clock);
  endtask

  task automatic release_reader();
    @(negedge clock);
    done = 1'b0;
    repeat (3) @(negedge clock);
    done = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++; if (fft_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", fft_tready); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bram_we); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (fft_tready !== 1'b1) begin n_fail++; $display("FAIL run_tready: got %b expected 1", fft_tready); end
  endtask

  task automatic test_first_frame();
    bit ok;
    int wr0;
    idle(2);
    drive(16'h0, 16'h0, 1'b1, 1'b1);
    wr0 = wr_cnt;
    send_frame(N, N - 1, 0, 0, 1'b1);
    wait_ready(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL first_ready: got 0 expected 1"); end
    n_checks++; if (mem_errs() != 0) begin n_fail++; $display("FAIL first_mem: got %0d bad bins expected 0", mem_errs()); end
    n_checks++; if (timing_errs() != 0) begin n_fail++; $display("FAIL first_wr_latency: got %0d late bins expected 0", timing_errs()); end
    n_checks++; if (wr_cnt - wr0 != N) begin n_fail++; $display("FAIL first_wr_count: got %0d expected %0d", wr_cnt - wr0, N); end
    n_checks++; if (ready_rise_cyc != last_cyc + 3) begin n_fail++; $display("FAIL first_ready_cycle: got %0d expected %0d", ready_rise_cyc, last_cyc + 3); end
  endtask

  task automatic test_handshake();
    int wr0;
    repeat (5) @(negedge clock);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_hold: got %b expected 1", ready); end
    done = 1'b0;
    @(negedge clock);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_fall: got %b expected 0", ready); end
    wr0 = wr_cnt;
    send_frame(200, 199, 1, 0, 1'b0);
    exp_drop++;
    idle(50);
    send_frame(150, 149, 1, 10, 1'b0);
    exp_drop++;
    idle(220);
    n_checks++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL drop_busy: got %0d expected %0d", drop_count, exp_drop); end
    n_checks++; if (wr_cnt != wr0) begin n_fail++; $display("FAIL no_write_busy: got %0d writes expected 0", wr_cnt - wr0); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_busy: got %b expected 0", ready); end
    done = 1'b1;
    repeat (3) @(negedge clock);
    drive(16'h1234, 16'h0, 1'b1, 1'b1);
    idle(3);
    n_checks++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL arm_tlast_not_dropped: got %0d expected %0d", drop_count, exp_drop); end
    n_checks++; if (wr_cnt != wr0) begin n_fail++; $display("FAIL arm_no_write: got %0d writes expected 0", wr_cnt - wr0); end
  endtask

  task automatic test_magnitude();
    bit ok;
    send_frame(N, N - 1, 2, 0, 1'b1);
    wait_ready(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mag_ready: got 0 expected 1"); end
    n_checks++; if (obs_mem[0] != 40960) begin n_fail++; $display("FAIL mag_most_negative: got %0d expected 40960", obs_mem[0]); end
    n_checks++; if (obs_mem[1] != 4750) begin n_fail++; $display("FAIL mag_3000_m4000: got %0d expected 4750", obs_mem[1]); end
    n_checks++; if (obs_mem[2] != 0) begin n_fail++; $display("FAIL mag_zero: got %0d expected 0", obs_mem[2]); end
    n_checks++; if (mem_errs() != 0) begin n_fail++; $display("FAIL mag_random_mem: got %0d bad bins expected 0", mem_errs()); end
    n_checks++; if (ready_rise_cyc != last_cyc + 3) begin n_fail++; $display("FAIL mag_ready_cycle: got %0d expected %0d", ready_rise_cyc, last_cyc + 3); end
  endtask

  task automatic test_short_frame();
    bit ok;
    int se0;
    release_reader();
    drive(16'h0, 16'h0, 1'b1, 1'b1);
    se0 = se_cnt;
    send_frame(700, 699, 1, 0, 1'b1);
    idle(8);
    n_checks++; if (se_cnt != se0 + 1) begin n_fail++; $display("FAIL short_sync_err: got %0d pulses expected 1", se_cnt - se0); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL short_not_ready: got %b expected 0", ready); end
    send_frame(N, N - 1, 1, 0, 1'b1);
    wait_ready(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL short_next_ready: got 0 expected 1"); end
    n_checks++; if (mem_errs() != 0) begin n_fail++; $display("FAIL short_next_mem: got %0d bad bins expected 0", mem_errs()); end
    n_checks++; if (se_cnt != se0 + 1) begin n_fail++; $display("FAIL short_next_no_err: got %0d pulses expected 1", se_cnt - se0); end
  endtask

  task automatic test_missing_tlast();
    bit ok;
    int se0, wr0;
    release_reader();
    drive(16'h0, 16'h0, 1'b1, 1'b1);
    se0 = se_cnt;
    wr0 = wr_cnt;
    send_frame(N, -1, 1, 0, 1'b1);
    send_frame(50, -1, 1, 0, 1'b0);
    idle(5);
    n_checks++; if (se_cnt != se0 + 1) begin n_fail++; $display("FAIL missing_sync_err: got %0d pulses expected 1", se_cnt - se0); end
    n_checks++; if (wr_cnt - wr0 != N) begin n_fail++; $display("FAIL missing_sync_discard: got %0d writes expected %0d", wr_cnt - wr0, N); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL missing_not_ready: got %b expected 0", ready); end
    drive(16'h0, 16'h0, 1'b1, 1'b1);
    idle(2);
    n_checks++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL sync_tlast_not_dropped: got %0d expected %0d", drop_count, exp_drop); end
    send_frame(N, N - 1, 1, 0, 1'b1);
    wait_ready(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL missing_next_ready: got 0 expected 1"); end
    n_checks++; if (mem_errs() != 0) begin n_fail++; $display("FAIL missing_next_mem: got %0d bad bins expected 0", mem_errs()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int wr0;
    @(negedge clock);
    done = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 260; k++) begin
      drive(16'h0, 16'h0, 1'b1, 1'b1);
      if (exp_drop < 255) exp_drop++;
    end
    idle(2);
    n_checks++; if (drop_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL drop_saturate: got %0d expected %0d", drop_count, exp_drop); end
    done = 1'b1;
    repeat (3) @(negedge clock);
    drive(16'h0, 16'h0, 1'b1, 1'b1);
    send_frame(500, -1, 1, 0, 1'b1);
    #2 reset_n = 1'b0;
    fft_tvalid = 1'b0;
    #1;
    n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b expected 0", bram_we); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", ready); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL midreset_drop: got %0d expected 0", drop_count); end
    exp_drop = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    wr0 = wr_cnt;
    send_frame(N, N - 1, 1, 0, 1'b0);
    idle(6);
    n_checks++; if (wr_cnt != wr0) begin n_fail++; $display("FAIL midreset_sync_discard: got %0d writes expected 0", wr_cnt - wr0); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midreset_not_ready: got %b expected 0", ready); end
    send_frame(N, N - 1, 1, 0, 1'b1);
    wait_ready(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_next_ready: got 0 expected 1"); end
    n_checks++; if (mem_errs() != 0) begin n_fail++; $display("FAIL midreset_next_mem: got %0d bad bins expected 0", mem_errs()); end
  endtask

  task automatic test_gaps();
    bit ok;
    release_reader();
    drive(16'h0, 16'h0, 1'b1, 1'b1);
    send_frame(N, N - 1, 1, 30, 1'b1);
    wait_ready(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL gaps_ready: got 0 expected 1"); end
    n_checks++; if (mem_errs() != 0) begin n_fail++; $display("FAIL gaps_mem: got %0d bad bins expected 0", mem_errs()); end
    n_checks++; if (timing_errs() != 0) begin n_fail++; $display("FAIL gaps_wr_latency: got %0d late bins expected 0", timing_errs()); end
    n_checks++; if (ready_rise_cyc != last_cyc + 3) begin n_fail++; $display("FAIL gaps_ready_cycle: got %0d expected %0d", ready_rise_cyc, last_cyc + 3); end
  endtask

  task automatic test_global();
    n_checks++; if (we_in_ready != 0) begin n_fail++; $display("FAIL write_while_ready: got %0d expected 0", we_in_ready); end
    n_checks++; if (se_wide != 0) begin n_fail++; $display("FAIL sync_err_width: got %0d long cycles expected 0", se_wide); end
    n_checks++; if (ready_rises != 6) begin n_fail++; $display("FAIL ready_frame_count: got %0d expected 6", ready_rises); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_handshake();
    test_magnitude();
    test_short_frame();
    test_missing_tlast();
    test_reset_mid();
    test_gaps();
    test_global();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
